// File: rtl/rf_arb_pkg.sv
// Shared widths and helpers for the register-file read-port arbiter.
package rf_arb_pkg;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int WAIT_CNT_W = 4;

  // Index of the set bit in a one-hot vector (up to 8 ports); 0 for an empty vector.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = r | 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW:0] pos;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_read_arbiter.sv
// Shares the register-file read mux among NUM_REQ requesters: port 0 has priority,
// the rest are round-robin with aging; two-stage grant -> data pipeline.
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [RF_ADDR_W*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [RF_ADDR_W-1:0]           mux_sel,
  input  logic [RF_DATA_W-1:0]           mux_out,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [RF_DATA_W-1:0]           rd_data
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int NLP   = NUM_REQ - 1;
  localparam int LPW   = (NLP > 1) ? $clog2(NLP) : 1;
  localparam logic [WAIT_CNT_W-1:0] SAT = WAIT_CNT_W'(MAX_WAIT);

  logic [NUM_REQ-1:0][RF_ADDR_W-1:0]  addr_v;
  logic [NUM_REQ-1:1][WAIT_CNT_W-1:0] wait_cnt;
  logic [NUM_REQ-1:0] elig, aged, forced, win;
  logic [NLP-1:0]     rr_win;
  logic [LPW-1:0]     rr_ofs;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt, owner, win_idx;
  logic               busy;

  assign addr_v = req_addr;

  // Port 0 is never self-excluded so decode can issue a fresh read every cycle;
  // low-priority ports holding req through their gnt pulse sit out one cycle.
  assign elig = req & ~{gnt[NUM_REQ-1:1], 1'b0};

  always_comb begin
    aged = '0;
    for (int i = 1; i < NUM_REQ; i++)
      aged[i] = elig[i] && (wait_cnt[i] == SAT);
  end

  // Isolate the lowest saturated port.
  assign forced = aged & (~aged + NUM_REQ'(1));

  assign rr_ofs = LPW'(rr_ptr - IDX_W'(1));

  rr_pick #(.N(NLP)) u_rr (
    .req (elig[NUM_REQ-1:1]),
    .ptr (rr_ofs),
    .gnt (rr_win)
  );

  always_comb begin
    if (|forced)      win = forced;
    else if (elig[0]) win = NUM_REQ'(1);
    else              win = {rr_win, 1'b0};
  end

  assign win_idx = IDX_W'(oh2idx(8'(win)));
  assign rr_nxt  = (win_idx == IDX_W'(NUM_REQ-1)) ? IDX_W'(1) : win_idx + IDX_W'(1);

  // Aging: only bypasses by port 0 count toward forcing a low-priority port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (!req[i] || win[i])
          wait_cnt[i] <= '0;
        else if (win[0] && wait_cnt[i] != SAT)
          wait_cnt[i] <= wait_cnt[i] + WAIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= '0;
      mux_sel  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= IDX_W'(1);
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      gnt  <= win;
      busy <= |win;
      if (|win) begin
        mux_sel <= addr_v[win_idx];
        owner   <= win_idx;
      end
      if (|win[NUM_REQ-1:1]) rr_ptr <= rr_nxt;
      // Data stage: mux_out reflects the mux_sel loaded by the previous grant.
      rd_valid <= busy ? (NUM_REQ'(1) << owner) : '0;
      if (busy) rd_data <= mux_out;
    end
  end
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Self-checking bench for rf_read_arbiter against a cycle-level behavioural model.
module tb_rf_read_arbiter;
  localparam int N  = 4;
  localparam int MW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [5*N-1:0] req_addr = '0;
  logic [N-1:0]  gnt, rd_valid;
  logic [4:0]    mux_sel;
  logic [31:0]   mux_out, rd_data;
  logic [31:0]   rf [32];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;
  assign mux_out = rf[mux_sel];

  rf_read_arbiter #(.NUM_REQ(N), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .mux_sel(mux_sel), .mux_out(mux_out),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  // Reference model state (values expected right after the next edge)
  logic [N-1:0] m_gnt, m_rdv;
  logic [4:0]   m_sel;
  logic [31:0]  m_rdd;
  logic         m_busy;
  int           m_owner, m_ptr;
  int           m_age [N];

  function automatic logic [5*N-1:0] pk(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic model_reset();
    m_gnt = '0; m_rdv = '0; m_sel = '0; m_rdd = '0; m_busy = 1'b0;
    m_owner = 0; m_ptr = 1;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [5*N-1:0] a);
    int w;
    int p;
    logic [4:0] ad [N];
    for (int i = 0; i < N; i++) ad[i] = a[5*i +: 5];
    w = -1;
    for (int i = 1; i < N; i++)
      if (w < 0 && r[i] && !m_gnt[i] && m_age[i] == MW) w = i;
    if (w < 0 && r[0]) w = 0;
    for (int k = 0; k < N-1; k++) begin
      p = 1 + (m_ptr - 1 + k) % (N-1);
      if (w < 0 && r[p] && !m_gnt[p]) w = p;
    end
    if (m_busy) begin
      m_rdv = N'(1) << m_owner;
      m_rdd = rf[m_sel];
    end else m_rdv = '0;
    for (int i = 1; i < N; i++) begin
      if (!r[i] || w == i) m_age[i] = 0;
      else if (w == 0 && m_age[i] < MW) m_age[i] = m_age[i] + 1;
    end
    if (w >= 1) m_ptr = (w == N-1) ? 1 : w + 1;
    m_gnt  = (w >= 0) ? (N'(1) << w) : '0;
    m_busy = (w >= 0);
    if (w >= 0) begin
      m_owner = w;
      m_sel   = ad[w];
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [5*N-1:0] a);
    req = r; req_addr = a;
    model_step(r, a);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    reset_n = 1'b0;
    repeat (3) begin
      req = N'($urandom); req_addr = (5*N)'($urandom);
      @(posedge clock); #1;
    end
    n_tests++;
    if ({gnt, rd_valid, mux_sel, rd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b rd_valid=%b mux_sel=%0d rd_data=%h, required all 0",
               gnt, rd_valid, mux_sel, rd_data);
    end
    req = '0; reset_n = 1'b1; model_reset();
    rf[5] = 32'h0000_0005;
    cyc(4'b0001, pk(5, 0, 0, 0));
    n_tests++;
    if (gnt !== 4'b0001 || mux_sel !== 5'd5 || rd_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt=%b mux_sel=%0d rd_valid=%b, required 0001/5/0000",
               gnt, mux_sel, rd_valid);
    end
    cyc(4'b0000, pk(5, 0, 0, 0));
    n_tests++;
    if (rd_valid !== 4'b0001 || rd_data !== 32'h5 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_first_data: rd_valid=%b rd_data=%h gnt=%b, required 0001/00000005/0000",
               rd_valid, rd_data, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1110, pk(0, 1, 2, 3));
      exp_g = N'(2) << (k % 3);
      n_tests++;
      if (gnt !== exp_g || gnt !== m_gnt) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b, required %b", k, gnt, exp_g);
      end
      if (k > 0) begin
        n_tests++;
        if (rd_valid !== (N'(2) << ((k-1) % 3)) || rd_data !== rf[((k-1) % 3) + 1]) begin
          n_fail++;
          $display("FAIL rr_data[%0d]: rd_valid=%b rd_data=%h, required %b/%h", k, rd_valid,
                   rd_data, N'(2) << ((k-1) % 3), rf[((k-1) % 3) + 1]);
        end
      end
    end
  endtask

  task automatic test_aging();
    logic [N-1:0] exp_g;
    cyc(4'b0000, '0);
    for (int k = 0; k < 18; k++) begin
      cyc(4'b0011, pk(5'd12, 5'd20, 0, 0));
      exp_g = (k % 9 == 8) ? 4'b0010 : 4'b0001;
      n_tests++;
      if (gnt !== exp_g || rd_valid !== m_rdv || rd_data !== m_rdd) begin
        n_fail++;
        $display("FAIL aging[%0d]: gnt=%b rd_valid=%b rd_data=%h, required %b/%b/%h",
                 k, gnt, rd_valid, rd_data, exp_g, m_rdv, m_rdd);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(4'b0000, '0);
    cyc(4'b0000, '0);
    cyc(4'b0001, pk(7, 0, 0, 0));
    n_tests++;
    if (gnt !== 4'b0001 || mux_sel !== 5'd7) begin
      n_fail++;
      $display("FAIL b2b_grant: gnt=%b mux_sel=%0d, required 0001/7", gnt, mux_sel);
    end
    cyc(4'b0001, pk(9, 0, 0, 0));
    n_tests++;
    if (rd_valid !== 4'b0001 || rd_data !== rf[7] || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_rd7: rd_valid=%b rd_data=%h, required 0001/%h", rd_valid, rd_data, rf[7]);
    end
    cyc(4'b0001, pk(31, 0, 0, 0));
    n_tests++;
    if (rd_valid !== 4'b0001 || rd_data !== rf[9]) begin
      n_fail++;
      $display("FAIL b2b_rd9: rd_valid=%b rd_data=%h, required 0001/%h", rd_valid, rd_data, rf[9]);
    end
    cyc(4'b0000, '0);
    n_tests++;
    if (rd_valid !== 4'b0001 || rd_data !== rf[31]) begin
      n_fail++;
      $display("FAIL b2b_rd31: rd_valid=%b rd_data=%h, required 0001/%h", rd_valid, rd_data, rf[31]);
    end
  endtask

  task automatic test_async_reset();
    cyc(4'b0000, '0);
    cyc(4'b0100, pk(0, 0, 6, 0));
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, rd_valid, mux_sel, rd_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: gnt=%b rd_valid=%b mux_sel=%0d rd_data=%h, required all 0",
               gnt, rd_valid, mux_sel, rd_data);
    end
    req = '0;
    @(posedge clock); #1;
    reset_n = 1'b1; model_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(4'b0000, '0);
      n_tests++;
      if (rd_valid !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_reset_no_valid[%0d]: rd_valid=%b, required 0000", k, rd_valid);
      end
    end
    cyc(4'b1110, pk(0, 1, 2, 3));
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL async_reset_rr_ptr: gnt=%b, required 0010", gnt);
    end
    cyc(4'b0000, '0);
  endtask

  task automatic test_idle();
    logic [4:0] a;
    a = 5'($urandom_range(1, 31));
    cyc(4'b0001, pk(a, 0, 0, 0));
    cyc(4'b0000, pk(a, 0, 0, 0));
    n_tests++;
    if (rd_valid !== 4'b0001 || rd_data !== rf[a]) begin
      n_fail++;
      $display("FAIL idle_last_read: rd_valid=%b rd_data=%h, required 0001/%h", rd_valid, rd_data, rf[a]);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0000, '0);
      n_tests++;
      if (gnt !== 4'b0000 || rd_valid !== 4'b0000 || mux_sel !== a) begin
        n_fail++;
        $display("FAIL idle[%0d]: gnt=%b rd_valid=%b mux_sel=%0d, required 0000/0000/%0d",
                 k, gnt, rd_valid, mux_sel, a);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [4:0]   ad [N];
    r = '0;
    for (int i = 0; i < N; i++) ad[i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!r[i] || m_gnt[i]) begin
          r[i]  = ($urandom_range(0, 2) != 0);
          ad[i] = 5'($urandom);
        end
      if (c % 16 == 0) rf[$urandom_range(0, 31)] = $urandom;
      cyc(r, pk(ad[0], ad[1], ad[2], ad[3]));
      n_tests++;
      if (gnt !== m_gnt || mux_sel !== m_sel || rd_valid !== m_rdv || rd_data !== m_rdd) begin
        n_fail++;
        $display("FAIL random[%0d]: gnt=%b sel=%0d rdv=%b rdd=%h, required %b/%0d/%b/%h",
                 c, gnt, mux_sel, rd_valid, rd_data, m_gnt, m_sel, m_rdv, m_rdd);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_aging();
    test_back_to_back();
    test_async_reset();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
